// File: rtl/cmd_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit command register bus between JTAG and
// the export port; drives the stretched write strobe and the soft-reset pulse.
module cmd_bus_arbiter #(
  parameter int unsigned STROBE_LEN = 20,
  parameter int unsigned RESET_LEN  = 50000,
  parameter logic [7:0]  SRST_ADDR  = 8'h01,
  parameter logic [7:0]  SRST_DATA  = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       jt_req,
  input  logic       jt_wr,
  input  logic [7:0] jt_addr,
  input  logic [7:0] jt_data,
  output logic       jt_ack,
  input  logic       ex_req,
  input  logic       ex_wr,
  input  logic [7:0] ex_addr,
  input  logic [7:0] ex_data,
  output logic       ex_ack,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_data,
  output logic       bus_we,
  output logic       reset_out,
  output logic       busy,
  output logic       grant_src
);

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    ACK,
    SRST,
    GAP
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        wr_q;
  logic [31:0] cnt;

  logic       pick_ex;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_data;

  // On a tie the source that did not win last time takes the bus.
  assign pick_ex = ex_req & (~jt_req | ~last_grant);

  always_comb begin
    req_wr   = jt_wr;
    req_addr = jt_addr;
    req_data = jt_data;
    if (pick_ex) begin
      req_wr   = ex_wr;
      req_addr = ex_addr;
      req_data = ex_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      wr_q       <= 1'b0;
      cnt        <= '0;
      grant_src  <= 1'b0;
      bus_addr   <= '0;
      bus_data   <= '0;
      bus_we     <= 1'b0;
      reset_out  <= 1'b0;
      busy       <= 1'b0;
      jt_ack     <= 1'b0;
      ex_ack     <= 1'b0;
    end else begin
      jt_ack <= 1'b0;
      ex_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (jt_req | ex_req) begin
            grant_src <= pick_ex;
            wr_q      <= req_wr;
            bus_addr  <= req_addr;
            busy      <= 1'b1;
            if (req_wr) begin
              bus_data <= req_data;
              bus_we   <= 1'b1;
              cnt      <= STROBE_LEN - 32'd1;
              state    <= STROBE;
            end else begin
              jt_ack <= ~pick_ex;
              ex_ack <= pick_ex;
              state  <= ACK;
            end
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            bus_we <= 1'b0;
            jt_ack <= ~grant_src;
            ex_ack <= grant_src;
            state  <= ACK;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        ACK: begin
          last_grant <= grant_src;
          // bus_data only tracks writes, so with wr_q set it is the latched data.
          if (wr_q && bus_addr == SRST_ADDR && bus_data == SRST_DATA) begin
            reset_out <= 1'b1;
            bus_addr  <= '0;
            cnt       <= RESET_LEN - 32'd1;
            state     <= SRST;
          end else begin
            state <= GAP;
          end
        end
        SRST: begin
          if (cnt == '0) begin
            reset_out <= 1'b0;
            state     <= GAP;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// Bench for cmd_bus_arbiter: transaction-timeline reference model, directed
// scenarios, random traffic, and a default-parameter soft-reset run.
module tb_cmd_bus_arbiter;

  localparam int L = 4;
  localparam int R = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       jt_req, jt_wr, jt_ack;
  logic [7:0] jt_addr, jt_data;
  logic       ex_req, ex_wr, ex_ack;
  logic [7:0] ex_addr, ex_data;
  logic [7:0] bus_addr, bus_data;
  logic       bus_we, reset_out, busy, grant_src;

  cmd_bus_arbiter #(.STROBE_LEN(L), .RESET_LEN(R)) dut (
    .clk(clk), .reset(reset),
    .jt_req(jt_req), .jt_wr(jt_wr), .jt_addr(jt_addr),
    .jt_data(jt_data), .jt_ack(jt_ack),
    .ex_req(ex_req), .ex_wr(ex_wr), .ex_addr(ex_addr),
    .ex_data(ex_data), .ex_ack(ex_ack),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
    .reset_out(reset_out), .busy(busy), .grant_src(grant_src)
  );

  logic       reset2;
  logic       jt2_req, jt2_wr, jt2_ack;
  logic [7:0] jt2_addr, jt2_data;
  logic       ex2_req, ex2_wr, ex2_ack;
  logic [7:0] ex2_addr, ex2_data;
  logic [7:0] bus2_addr, bus2_data;
  logic       bus2_we, reset2_out, busy2, grant2_src;

  cmd_bus_arbiter d2 (
    .clk(clk), .reset(reset2),
    .jt_req(jt2_req), .jt_wr(jt2_wr), .jt_addr(jt2_addr),
    .jt_data(jt2_data), .jt_ack(jt2_ack),
    .ex_req(ex2_req), .ex_wr(ex2_wr), .ex_addr(ex2_addr),
    .ex_data(ex2_data), .ex_ack(ex2_ack),
    .bus_addr(bus2_addr), .bus_data(bus2_data), .bus_we(bus2_we),
    .reset_out(reset2_out), .busy(busy2), .grant_src(grant2_src)
  );

  int ncmp = 0;
  int nfail = 0;

  // Reference model: one record for the transaction in flight, with
  // every output derived from its start edge by window arithmetic.
  int         cyc = 0;
  int         free_at = 0;
  int         t0 = 0;
  bit         act = 0;
  bit         lg = 1;
  bit         m_wr, m_src, m_srst;
  logic [7:0] e_addr = '0;
  logic [7:0] e_data = '0;
  int         grants[$];
  int         n_grant, we_cnt, rst_cnt, jack_cnt, eack_cnt, ack_lat;
  bit         rnd_mode = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_model();
    cyc++;
    if (!reset) begin
      act = 0;
      lg = 1;
      free_at = cyc + 1;
      e_addr = '0;
      e_data = '0;
    end else if (cyc >= free_at && (jt_req || ex_req)) begin
      m_src = ex_req && (!jt_req || !lg);
      lg = m_src;
      act = 1;
      t0 = cyc;
      m_wr = m_src ? ex_wr : jt_wr;
      e_addr = m_src ? ex_addr : jt_addr;
      if (m_wr) e_data = m_src ? ex_data : jt_data;
      m_srst = m_wr && e_addr == 8'h01 && e_data == 8'h02;
      free_at = cyc + (m_wr ? (m_srst ? L + R + 3 : L + 3) : 3);
      grants.push_back(int'(m_src));
      n_grant++;
    end
    if (act && m_srst && cyc == t0 + L + 1) e_addr = '0;
  endtask

  task automatic compare();
    int  d;
    bit  busy_e, we_e, ja_e, ea_e, ro_e;
    d = cyc - t0;
    busy_e = act && cyc <= free_at - 2;
    we_e = act && m_wr && d < L;
    ja_e = act && !m_src && d == (m_wr ? L : 0);
    ea_e = act && m_src && d == (m_wr ? L : 0);
    ro_e = act && m_srst && d >= L + 1 && d <= L + R;
    chk("busy", 32'(busy), 32'(busy_e));
    chk("bus_we", 32'(bus_we), 32'(we_e));
    chk("jt_ack", 32'(jt_ack), 32'(ja_e));
    chk("ex_ack", 32'(ex_ack), 32'(ea_e));
    chk("reset_out", 32'(reset_out), 32'(ro_e));
    chk("bus_addr", 32'(bus_addr), 32'(e_addr));
    chk("bus_data", 32'(bus_data), 32'(e_data));
    if (busy_e) chk("grant_src", 32'(grant_src), 32'(m_src));
  endtask

  task automatic tick();
    @(posedge clk);
    edge_model();
    @(negedge clk);
    compare();
    if (bus_we) we_cnt++;
    if (reset_out) rst_cnt++;
    if (jt_ack || ex_ack) ack_lat = cyc - t0;
    if (jt_ack) begin jt_ack_seen(); end
    if (ex_ack) begin eack_cnt++; ex_req = 0; end
    if (rnd_mode) begin
      if (!jt_req && !jt_ack && $urandom_range(3) == 0) begin
        jt_req = 1;
        jt_wr = $urandom_range(3) != 0;
        jt_addr = 8'($urandom);
        jt_data = 8'($urandom);
        if ($urandom_range(7) == 0) begin
          jt_addr = 8'h01; jt_data = 8'h02;
        end
      end
      if (!ex_req && !ex_ack && $urandom_range(3) == 0) begin
        ex_req = 1;
        ex_wr = $urandom_range(3) != 0;
        ex_addr = 8'($urandom);
        ex_data = 8'($urandom);
        if ($urandom_range(7) == 0) begin
          ex_addr = 8'h01; ex_data = 8'h02;
        end
      end
    end
  endtask

  task automatic jt_ack_seen();
    jack_cnt++;
    jt_req = 0;
  endtask

  task automatic clr();
    we_cnt = 0; rst_cnt = 0; jack_cnt = 0; eack_cnt = 0;
    n_grant = 0; ack_lat = -1;
    grants.delete();
  endtask

  task automatic do_reset();
    reset = 0; jt_req = 0; ex_req = 0;
    tick(); tick();
    reset = 1;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    while ((jt_req || ex_req || cyc < free_at - 1) && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < maxc), 32'd1);
  endtask

  initial begin
    int exp_g[4];
    int n2, we2, ro2, ack2;
    bit started;
    exp_g = '{0, 1, 0, 1};
    reset = 0; reset2 = 0;
    jt_req = 0; jt_wr = 0; jt_addr = 0; jt_data = 0;
    ex_req = 0; ex_wr = 0; ex_addr = 0; ex_data = 0;
    jt2_req = 0; jt2_wr = 0; jt2_addr = 0; jt2_data = 0;
    ex2_req = 0; ex2_wr = 0; ex2_addr = 0; ex2_data = 0;
    clr();

    do_reset();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_src), 32'd0);

    // JTAG write
    clr();
    jt_wr = 1; jt_addr = 8'h10; jt_data = 8'hA5; jt_req = 1;
    wait_idle("t1_timeout", 40);
    chk("t1_we_cnt", 32'(we_cnt), 32'(L));
    chk("t1_jack", 32'(jack_cnt), 32'd1);
    chk("t1_eack", 32'(eack_cnt), 32'd0);
    chk("t1_lat", 32'(ack_lat), 32'(L));
    chk("t1_addr", 32'(bus_addr), 32'h10);
    chk("t1_data", 32'(bus_data), 32'hA5);

    // Repeated ties alternate
    do_reset();
    clr();
    jt_wr = 1; jt_addr = 8'h20; jt_data = 8'h11; jt_req = 1;
    ex_wr = 1; ex_addr = 8'h21; ex_data = 8'h22; ex_req = 1;
    wait_idle("t2a_timeout", 60);
    jt_wr = 1; jt_addr = 8'h24; jt_data = 8'h33; jt_req = 1;
    ex_wr = 1; ex_addr = 8'h25; ex_data = 8'h44; ex_req = 1;
    wait_idle("t2b_timeout", 60);
    chk("t2_ngrant", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++)
      chk("t2_order", 32'(grants[i]), 32'(exp_g[i]));
    chk("t2_jack", 32'(jack_cnt), 32'd2);
    chk("t2_eack", 32'(eack_cnt), 32'd2);

    // Export address-only set
    clr();
    ex_wr = 0; ex_addr = 8'h33; ex_data = 8'hEE; ex_req = 1;
    wait_idle("t3_timeout", 20);
    chk("t3_we_cnt", 32'(we_cnt), 32'd0);
    chk("t3_eack", 32'(eack_cnt), 32'd1);
    chk("t3_lat", 32'(ack_lat), 32'd0);
    chk("t3_addr", 32'(bus_addr), 32'h33);
    chk("t3_data", 32'(bus_data), 32'h44);

    // Export soft-reset command
    clr();
    ex_wr = 1; ex_addr = 8'h01; ex_data = 8'h02; ex_req = 1;
    wait_idle("t4_timeout", 60);
    chk("t4_we_cnt", 32'(we_cnt), 32'(L));
    chk("t4_rst_cnt", 32'(rst_cnt), 32'(R));
    chk("t4_eack", 32'(eack_cnt), 32'd1);
    chk("t4_addr", 32'(bus_addr), 32'h00);
    chk("t4_busy", 32'(busy), 32'd0);

    // Reset during strobe cycle 2
    do_reset();
    clr();
    jt_wr = 1; jt_addr = 8'h40; jt_data = 8'h5A; jt_req = 1;
    tick(); tick();
    reset = 0;
    tick();
    reset = 1;
    chk("t5_we", 32'(bus_we), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_noack", 32'(jack_cnt + eack_cnt), 32'd0);
    wait_idle("t5_timeout", 40);
    chk("t5_jack", 32'(jack_cnt), 32'd1);
    chk("t5_we_cnt", 32'(we_cnt), 32'(2 + L));
    chk("t5_data", 32'(bus_data), 32'h5A);

    // Random traffic from both sides
    do_reset();
    clr();
    rnd_mode = 1;
    repeat (600) tick();
    rnd_mode = 0;
    wait_idle("rnd_timeout", 200);
    chk("rnd_acks", 32'(jack_cnt + eack_cnt), 32'(n_grant));

    // Default parameters: full-length strobe and soft reset
    @(negedge clk);
    reset2 = 1;
    jt2_wr = 1; jt2_addr = 8'h01; jt2_data = 8'h02; jt2_req = 1;
    n2 = 0; we2 = 0; ro2 = 0; ack2 = 0; started = 0;
    while (n2 < 60000 && !(started && !busy2)) begin
      @(negedge clk);
      n2++;
      if (busy2) started = 1;
      if (bus2_we) we2++;
      if (reset2_out) ro2++;
      if (jt2_ack) begin ack2++; jt2_req = 0; end
    end
    chk("t6_timeout", 32'(n2 < 60000), 32'd1);
    chk("t6_we_cnt", 32'(we2), 32'd20);
    chk("t6_rst_cnt", 32'(ro2), 32'd50000);
    chk("t6_jack", 32'(ack2), 32'd1);
    chk("t6_addr", 32'(bus2_addr), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
